// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush controller.
// Enum of controller states, control bundle and common encodings.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_INIT     = 2'd0,
    S_RUN      = 2'd1,
    S_MEM_WAIT = 2'd2,
    S_ERR      = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic pc_en;
    logic pc_redirect;
    logic if_id_en;
    logic id_ex_en;
    logic ex_mem_en;
    logic mem_wb_en;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic mem_wb_flush;
  } pipe_ctrl_t;

  localparam pipe_ctrl_t CTRL_BUBBLE = '{
    pc_en: 1'b0, pc_redirect: 1'b0,
    if_id_en: 1'b1, id_ex_en: 1'b1,
    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b1, id_ex_flush: 1'b1,
    ex_mem_flush: 1'b1, mem_wb_flush: 1'b1
  };

  localparam pipe_ctrl_t CTRL_HALT = '0;

  localparam pipe_ctrl_t CTRL_RUN = '{
    pc_en: 1'b1, pc_redirect: 1'b0,
    if_id_en: 1'b1, id_ex_en: 1'b1,
    ex_mem_en: 1'b1, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0,
    ex_mem_flush: 1'b0, mem_wb_flush: 1'b0
  };

  // Frozen front end while the MEM stage waits; MEM/WB gets a bubble.
  localparam pipe_ctrl_t CTRL_MWAIT = '{
    pc_en: 1'b0, pc_redirect: 1'b0,
    if_id_en: 1'b0, id_ex_en: 1'b0,
    ex_mem_en: 1'b0, mem_wb_en: 1'b1,
    if_id_flush: 1'b0, id_ex_flush: 1'b0,
    ex_mem_flush: 1'b0, mem_wb_flush: 1'b1
  };

  // Branch redirect wins over load-use: the stalled op is squashed.
  function automatic pipe_ctrl_t hz_resolve(
    input logic br,
    input logic lu
  );
    pipe_ctrl_t c;
    c = CTRL_RUN;
    if (br) begin
      c.pc_redirect = 1'b1;
      c.if_id_flush = 1'b1;
      c.id_ex_flush = 1'b1;
    end else if (lu) begin
      c.pc_en       = 1'b0;
      c.if_id_en    = 1'b0;
      c.id_ex_flush = 1'b1;
    end
    return c;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use comparator between ID/EX load and IF/ID sources.
// Checks both rs fields; false stalls for rs2-less ops are harmless.
module load_use_detect (
  input  logic       ex_memread,
  input  logic [4:0] ex_rd,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  output logic       load_use
);

  assign load_use = ex_memread && (ex_rd != 5'd0) &&
                    ((ex_rd == id_rs1) || (ex_rd == id_rs2));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline and PC.
// Optional perf counters under PIPE_HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int RESET_HOLD  = 2,
  parameter int MEM_TIMEOUT = 64
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,parameter int CNT_W      = 32
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_memread,
  input  logic       ex_branch_taken,
  input  logic       mem_memread,
  input  logic       mem_memwrite,
  input  logic       dmem_ready,
  output logic       pc_en,
  output logic       pc_redirect,
  output logic       if_id_en,
  output logic       id_ex_en,
  output logic       ex_mem_en,
  output logic       mem_wb_en,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       ex_mem_flush,
  output logic       mem_wb_flush,
  output logic       mem_timeout,
  output logic [1:0] ctrl_state
`ifdef PIPE_HAZARD_PERF_CNT_EN
  ,output logic [CNT_W-1:0] stall_cycles
  ,output logic [CNT_W-1:0] flush_events
  ,output logic [CNT_W-1:0] mem_wait_cycles
`endif
);

  localparam int HCW =
    (RESET_HOLD < 2) ? 1 : $clog2(RESET_HOLD + 1);
  localparam int WCW =
    (MEM_TIMEOUT < 1) ? 1 : $clog2(MEM_TIMEOUT + 1);

  hz_state_e  state_q, state_d;
  logic [HCW-1:0] hold_q, hold_d;
  logic [WCW-1:0] wait_q, wait_d;
  pipe_ctrl_t ctrl;
  logic       load_use;
  logic       mem_stall;
  logic       lu_app;
  logic       mw_app;

  load_use_detect u_lud (
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .load_use   (load_use)
  );

  assign mem_stall = (mem_memread || mem_memwrite) && !dmem_ready;

  // State, hold counter and wait counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      hold_q  <= HCW'(RESET_HOLD);
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
      wait_q  <= wait_d;
    end
  end

  // Next-state and control bundle from state and hazard inputs.
  always_comb begin
    ctrl    = CTRL_BUBBLE;
    state_d = state_q;
    hold_d  = hold_q;
    wait_d  = wait_q;
    lu_app  = 1'b0;
    mw_app  = 1'b0;
    unique case (state_q)
      S_INIT: begin
        if (hold_q <= HCW'(1)) state_d = S_RUN;
        else hold_d = hold_q - HCW'(1);
      end
      S_RUN: begin
        if (mem_stall) begin
          ctrl    = CTRL_MWAIT;
          mw_app  = 1'b1;
          state_d = S_MEM_WAIT;
          wait_d  = WCW'(1);
        end else begin
          ctrl   = hz_resolve(ex_branch_taken, load_use);
          lu_app = load_use && !ex_branch_taken;
        end
      end
      S_MEM_WAIT: begin
        if (!dmem_ready) begin
          ctrl   = CTRL_MWAIT;
          mw_app = 1'b1;
          if (wait_q != '1) wait_d = wait_q + WCW'(1);
          if ((MEM_TIMEOUT != 0) &&
              (wait_q == WCW'(MEM_TIMEOUT)))
            state_d = S_ERR;
        end else begin
          ctrl    = hz_resolve(ex_branch_taken, load_use);
          state_d = S_RUN;
          wait_d  = '0;
        end
      end
      S_ERR: begin
        ctrl = CTRL_HALT;
      end
      default: begin
        ctrl    = CTRL_BUBBLE;
        state_d = S_INIT;
      end
    endcase
  end

  assign pc_en        = ctrl.pc_en;
  assign pc_redirect  = ctrl.pc_redirect;
  assign if_id_en     = ctrl.if_id_en;
  assign id_ex_en     = ctrl.id_ex_en;
  assign ex_mem_en    = ctrl.ex_mem_en;
  assign mem_wb_en    = ctrl.mem_wb_en;
  assign if_id_flush  = ctrl.if_id_flush;
  assign id_ex_flush  = ctrl.id_ex_flush;
  assign ex_mem_flush = ctrl.ex_mem_flush;
  assign mem_wb_flush = ctrl.mem_wb_flush;
  assign mem_timeout  = (state_q == S_ERR);
  assign ctrl_state   = state_q;

`ifdef PIPE_HAZARD_PERF_CNT_EN
  // Saturating counters of applied stalls, redirects and waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles    <= '0;
      flush_events    <= '0;
      mem_wait_cycles <= '0;
    end else begin
      if (lu_app && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_W'(1);
      if (ctrl.pc_redirect && flush_events != '1)
        flush_events <= flush_events + CNT_W'(1);
      if (mw_app && mem_wait_cycles != '1)
        mem_wait_cycles <= mem_wait_cycles + CNT_W'(1);
    end
  end
`else
  logic unused_perf;
  assign unused_perf = lu_app ^ mw_app;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl.
// RESET_HOLD=2, MEM_TIMEOUT=4; perf checks under the perf macro.
module tb_pipe_hazard_ctrl;

  logic       clk;
  logic       rst_n;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       ex_memread, ex_branch_taken;
  logic       mem_memread, mem_memwrite, dmem_ready;
  logic       pc_en, pc_redirect;
  logic       if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
  logic       if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
  logic       mem_timeout;
  logic [1:0] ctrl_state;
`ifdef PIPE_HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles, flush_events, mem_wait_cycles;
`endif

  int nvec = 0;
  int nerr = 0;

  // order: pc_en redir en(if,id,ex,wb) flush(if,id,ex,wb)
  localparam logic [9:0] V_BUB = 10'b00_1111_1111;
  localparam logic [9:0] V_RUN = 10'b10_1111_0000;
  localparam logic [9:0] V_BR  = 10'b11_1111_1100;
  localparam logic [9:0] V_LU  = 10'b00_0111_0100;
  localparam logic [9:0] V_MS  = 10'b00_0001_0001;
  localparam logic [9:0] V_ERR = 10'b00_0000_0000;

  pipe_hazard_ctrl #(
    .RESET_HOLD  (2),
    .MEM_TIMEOUT (4)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .ex_rd           (ex_rd),
    .ex_memread      (ex_memread),
    .ex_branch_taken (ex_branch_taken),
    .mem_memread     (mem_memread),
    .mem_memwrite    (mem_memwrite),
    .dmem_ready      (dmem_ready),
    .pc_en           (pc_en),
    .pc_redirect     (pc_redirect),
    .if_id_en        (if_id_en),
    .id_ex_en        (id_ex_en),
    .ex_mem_en       (ex_mem_en),
    .mem_wb_en       (mem_wb_en),
    .if_id_flush     (if_id_flush),
    .id_ex_flush     (id_ex_flush),
    .ex_mem_flush    (ex_mem_flush),
    .mem_wb_flush    (mem_wb_flush),
    .mem_timeout     (mem_timeout),
    .ctrl_state      (ctrl_state)
`ifdef PIPE_HAZARD_PERF_CNT_EN
    ,.stall_cycles    (stall_cycles)
    ,.flush_events    (flush_events)
    ,.mem_wait_cycles (mem_wait_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {19'd0, mem_timeout, ctrl_state,
            pc_en, pc_redirect,
            if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
            if_id_flush, id_ex_flush,
            ex_mem_flush, mem_wb_flush};
  endfunction

  function automatic logic [31:0] mk(
    input logic       to,
    input logic [1:0] st,
    input logic [9:0] c
  );
    return {19'd0, to, st, c};
  endfunction

  // check mid-cycle, then advance past the next edge
  task automatic cyc(input string tag, input logic [31:0] exp);
    @(negedge clk);
    chk(tag, obs(), exp);
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
    ex_memread = 1'b0; ex_branch_taken = 1'b0;
    mem_memread = 1'b0; mem_memwrite = 1'b0;
    dmem_ready = 1'b1;
  endtask

  task automatic lu_set(input logic [4:0] rd, input logic [4:0] r2);
    ex_memread = 1'b1; ex_rd = rd; id_rs2 = r2;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    @(negedge clk);
    chk("rst", obs(), mk(0, 2'd0, V_BUB));
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("init0", mk(0, 2'd0, V_BUB));
    cyc("init1", mk(0, 2'd0, V_BUB));
    cyc("run", mk(0, 2'd1, V_RUN));

    lu_set(5'd5, 5'd5);
    cyc("lu_rs2", mk(0, 2'd1, V_LU));
    ex_memread = 1'b0;
    cyc("lu_noload", mk(0, 2'd1, V_RUN));
    lu_set(5'd0, 5'd0);
    cyc("lu_x0", mk(0, 2'd1, V_RUN));
    idle();
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7;
    cyc("lu_rs1", mk(0, 2'd1, V_LU));
    idle();

    lu_set(5'd5, 5'd5);
    ex_branch_taken = 1'b1;
    cyc("br_lu", mk(0, 2'd1, V_BR));
    idle();

    mem_memwrite = 1'b1;
    cyc("st_ready", mk(0, 2'd1, V_RUN));
    idle();

    mem_memread = 1'b1; dmem_ready = 1'b0;
    ex_branch_taken = 1'b1;
    cyc("ms0", mk(0, 2'd1, V_MS));
    cyc("ms1", mk(0, 2'd2, V_MS));
    cyc("ms2", mk(0, 2'd2, V_MS));
    dmem_ready = 1'b1;
    cyc("ms_rel", mk(0, 2'd2, V_BR));
    idle();
    cyc("ms_after", mk(0, 2'd1, V_RUN));

    mem_memwrite = 1'b1; dmem_ready = 1'b0;
    cyc("to_run", mk(0, 2'd1, V_MS));
    for (int i = 0; i < 4; i++)
      cyc("to_wait", mk(0, 2'd2, V_MS));
    cyc("to_err", mk(1, 2'd3, V_ERR));
    idle();
    cyc("err_sticky", mk(1, 2'd3, V_ERR));

    rst_n = 1'b0;
    #1;
    chk("rst_async", obs(), mk(0, 2'd0, V_BUB));
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("pc_clr_s", stall_cycles, 32'd0);
    chk("pc_clr_f", flush_events, 32'd0);
    chk("pc_clr_m", mem_wait_cycles, 32'd0);
`endif
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc("re_init0", mk(0, 2'd0, V_BUB));
    cyc("re_init1", mk(0, 2'd0, V_BUB));

    lu_set(5'd9, 5'd9);
    cyc("p_lu0", mk(0, 2'd1, V_LU));
    cyc("p_lu1", mk(0, 2'd1, V_LU));
    idle();
    ex_branch_taken = 1'b1;
    cyc("p_br", mk(0, 2'd1, V_BR));
    idle();
    mem_memread = 1'b1; dmem_ready = 1'b0;
    cyc("p_ms0", mk(0, 2'd1, V_MS));
    cyc("p_ms1", mk(0, 2'd2, V_MS));
    cyc("p_ms2", mk(0, 2'd2, V_MS));
    dmem_ready = 1'b1;
    cyc("p_rel", mk(0, 2'd2, V_RUN));
    idle();
    cyc("p_end", mk(0, 2'd1, V_RUN));
`ifdef PIPE_HAZARD_PERF_CNT_EN
    chk("pc_stall", stall_cycles, 32'd2);
    chk("pc_flush", flush_events, 32'd1);
    chk("pc_mwait", mem_wait_cycles, 32'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             nvec, nerr);
    $finish;
  end

endmodule
